// File: rtl/pwm_multicanal.sv
// pwm_multicanal: C-channel PWM sharing one prescaler and period counter, edge or center aligned,
// with shadow/active duty buffering reloaded only at period boundaries.
module pwm_multicanal #(
  parameter int R = 6,
  parameter int N = 3,
  parameter int C = 4,
  localparam int SW = (C > 1) ? $clog2(C) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          align,
  input  logic          duty_we,
  input  logic [SW-1:0] duty_sel,
  input  logic [R-1:0]  duty_in,
  output logic [C-1:0]  pwm_out,
  output logic          period_tick
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [R-1:0] MAX = '1;
  logic [PW-1:0] pre_q, pre_d;
  logic [R-1:0]  cnt_q, cnt_d;
  logic          dir_q, dir_d, mode_q, mode_d;
  logic [R-1:0]  shadow_q [C];
  logic [R-1:0]  shadow_d [C];
  logic [R-1:0]  active_q [C];
  logic [R-1:0]  active_d [C];
  logic [C-1:0]  pwm_d;
  logic          tick, boundary;
  always_comb begin
    tick = enable && (pre_q == PW'(N - 1));
    // dir_q=1 means counting down; the center boundary is the step from 1 to 0
    boundary = tick && (mode_q ? (dir_q && cnt_q == R'(1)) : (cnt_q == MAX));
    pre_d = (!enable || tick) ? '0 : pre_q + 1'b1;
    cnt_d = (!enable || boundary) ? '0
          : !tick ? cnt_q
          : (mode_q && (dir_q || cnt_q == MAX)) ? cnt_q - 1'b1
          : cnt_q + 1'b1;
    dir_d = (!enable || boundary) ? 1'b0 : (tick && mode_q && cnt_q == MAX) ? 1'b1 : dir_q;
    mode_d = (!enable || boundary) ? align : mode_q;
    for (int k = 0; k < C; k++) begin
      shadow_d[k] = (duty_we && duty_sel == SW'(k)) ? duty_in : shadow_q[k];
      // while idle, active follows the shadow so the first enabled period is already current
      active_d[k] = !enable ? shadow_d[k] : boundary ? shadow_q[k] : active_q[k];
      pwm_d[k] = enable && (cnt_q < active_q[k]);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      mode_q      <= 1'b0;
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pwm_out     <= pwm_d;
      period_tick <= boundary;
    end
  end
endmodule

// File: tb/tb_pwm_multicanal.sv
// tb_pwm_multicanal: directed checks of period, duty, buffering, center mode, out-of-range writes and reset.
module tb_pwm_multicanal;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       align = 1'b0;
  logic       duty_we = 1'b0;
  logic [1:0] duty_sel = '0;
  logic [5:0] duty_in = '0;
  logic [3:0] pwm_out;
  logic       period_tick;
  logic [2:0] pwm3;
  logic       tick3;
  int n_pass = 0, n_total = 0;
  int hi [4];
  int hi3 [3];
  int ticks, ticks3, n;

  pwm_multicanal #(.R(6), .N(3), .C(4)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .align(align), .duty_we(duty_we),
    .duty_sel(duty_sel), .duty_in(duty_in), .pwm_out(pwm_out), .period_tick(period_tick)
  );
  pwm_multicanal #(.R(6), .N(3), .C(3)) u_c3 (
    .clk(clk), .reset(reset), .enable(enable), .align(align), .duty_we(duty_we),
    .duty_sel(duty_sel), .duty_in(duty_in), .pwm_out(pwm3), .period_tick(tick3)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic run(input int cycles);
    ticks = 0;
    ticks3 = 0;
    hi = '{default: 0};
    hi3 = '{default: 0};
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      ticks += int'(period_tick);
      ticks3 += int'(tick3);
      for (int k = 0; k < 4; k++) hi[k] += int'(pwm_out[k]);
      for (int k = 0; k < 3; k++) hi3[k] += int'(pwm3[k]);
    end
  endtask

  task automatic wait_tick(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!period_tick && cycles < 500);
    chk(tag, int'(period_tick), 1);
  endtask

  task automatic wr(input logic [1:0] sel, input logic [5:0] val);
    duty_sel = sel;
    duty_in = val;
    duty_we = 1'b1;
    @(posedge clk); #1;
    duty_we = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_tick", int'(period_tick), 0);
    reset = 1'b0;
    enable = 1'b1;
    wait_tick("t1_first", n);
    wait_tick("t1_next", n);
    chk("t1_period", n, 192);
    run(192);
    chk("t1_hi", hi[0] + hi[1] + hi[2] + hi[3], 0);
    chk("t1_ticks", ticks, 1);
    chk("t1_ticks_c3", ticks3, 1);

    wr(0, 16); wr(1, 32); wr(2, 63); wr(3, 0);
    wait_tick("t2_load", n);
    run(192);
    chk("t2_ch0", hi[0], 48);
    chk("t2_ch1", hi[1], 96);
    chk("t2_ch2", hi[2], 189);
    chk("t2_ch3", hi[3], 0);
    chk("t2_ticks", ticks, 1);

    wr(0, 8);
    wait_tick("t3_load", n);
    run(100);
    chk("t3_ch0_a", hi[0], 24);
    wr(0, 16);
    run(91);
    chk("t3_ch0_hold", hi[0], 0);
    chk("t3_ticks", ticks, 1);
    run(192);
    chk("t3_ch0_new", hi[0], 48);

    wr(3, 50);
    wait_tick("t5_oor_load", n);
    run(192);
    chk("t5_ch3", hi[3], 150);
    chk("t5_c3_ch0", hi3[0], 48);
    chk("t5_c3_ch1", hi3[1], 96);
    chk("t5_c3_ch2", hi3[2], 189);

    align = 1'b1;
    wait_tick("t4_switch", n);
    wait_tick("t4_next", n);
    chk("t4_period", n, 378);
    chk("t4_valley", int'(pwm_out[0]), 1);
    run(378);
    chk("t4_ch0", hi[0], 93);
    chk("t4_ch1", hi[1], 189);
    chk("t4_ch2", hi[2], 375);
    chk("t4_ch3", hi[3], 297);
    chk("t4_ticks", ticks, 1);
    align = 1'b0;
    wait_tick("t4_back", n);
    wait_tick("t4_edge", n);
    chk("t4_edge_period", n, 192);

    run(191);
    duty_sel = 2'd1;
    duty_in = 6'd8;
    duty_we = 1'b1;
    @(posedge clk); #1;
    duty_we = 1'b0;
    chk("t5_coincide_tick", int'(period_tick), 1);
    run(192);
    chk("t5_ch1_old", hi[1], 96);
    run(192);
    chk("t5_ch1_new", hi[1], 24);

    wr(1, 32);
    wait_tick("t6_load", n);
    wait_tick("t6_next", n);
    run(20);
    chk("t6_pre_ch1", hi[1], 20);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_pwm", int'(pwm_out), 0);
    chk("t6_rst_tick", int'(period_tick), 0);
    reset = 1'b0;
    run(400);
    chk("t6_ch1_low", hi[1], 0);
    chk("t6_all_low", hi[0] + hi[2] + hi[3] + hi3[0] + hi3[1] + hi3[2], 0);
    chk("t6_ticks", ticks, 2);

    wr(0, 16);
    wait_tick("t7_load", n);
    run(10);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("t7_dis_pwm", int'(pwm_out), 0);
    run(50);
    chk("t7_dis_hi", hi[0], 0);
    chk("t7_dis_ticks", ticks, 0);
    enable = 1'b1;
    run(192);
    chk("t7_en_ch0", hi[0], 48);
    chk("t7_en_ticks", ticks, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
